icache_refill_ctrl: RTL and testbench

ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

---
 rtl/icache_refill_ctrl.sv | 102 ++++++++++
 tb/tb_icache_refill_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : icache_refill_ctrl
// Purpose  : Fetches a missing I-cache line beat by beat and writes it to RAM.
// Revision : 1.0 - initial release
// ============================================================================
module icache_refill_ctrl #(
    parameter int LINE_WIDTH = 128,
    parameter int BEAT_WIDTH = 32,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_req,
    input  logic [31:0]           miss_addr,
    input  logic                  kill,
    output logic                  miss_ack,
    output logic                  busy,
    output logic                  mem_req,
    output logic [31:0]           mem_addr,
    input  logic                  mem_ack,
    input  logic [BEAT_WIDTH-1:0] mem_rdata,
    output logic                  ram_req,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [LINE_WIDTH-1:0] ram_wdata
);

    localparam int c_NUM_BEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int c_BEAT_BITS = $clog2(c_NUM_BEATS);
    localparam int c_OFF_BITS  = $clog2(LINE_WIDTH / 8);
    localparam int c_BYTE_BITS = $clog2(BEAT_WIDTH / 8);
    localparam logic [c_BEAT_BITS-1:0] c_LAST_BEAT = c_BEAT_BITS'(c_NUM_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t                   r_state;
    logic [31-c_OFF_BITS:0]   r_line_addr;
    logic [c_BEAT_BITS-1:0]   r_beat;
    logic                     r_kill;
    logic [LINE_WIDTH-1:0]    r_line;
    logic                     w_unused_offset;

    // Byte offset within the line never reaches the memory or RAM side.
    assign w_unused_offset = ^miss_addr[c_OFF_BITS-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_line_addr <= '0;
            r_beat      <= '0;
            r_kill      <= 1'b0;
            r_line      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (miss_req) begin
                        r_line_addr <= miss_addr[31:c_OFF_BITS];
                        r_beat      <= '0;
                        r_kill      <= 1'b0;
                        r_state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (mem_ack) begin
                        r_line[int'(r_beat)*BEAT_WIDTH +: BEAT_WIDTH] <= mem_rdata;
                        r_beat <= r_beat + 1'b1;
                        // A pending or same-cycle kill ends the refill at this beat.
                        if (r_kill || kill) begin
                            r_state <= IDLE;
                        end else if (r_beat == c_LAST_BEAT) begin
                            r_state <= WRITE;
                        end
                    end else if (kill) begin
                        r_kill <= 1'b1;
                    end
                end
                WRITE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state != IDLE);
    assign mem_req   = (r_state == FETCH);
    assign mem_addr  = {r_line_addr, r_beat, {c_BYTE_BITS{1'b0}}};
    assign ram_req   = (r_state == WRITE);
    assign ram_wr_en = (r_state == WRITE);
    assign miss_ack  = (r_state == WRITE);
    assign ram_addr  = r_line_addr[ADDR_WIDTH-1:0];
    assign ram_wdata = r_line;

endmodule
`default_nettype wire

// File: tb/tb_icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_refill_ctrl
// Purpose  : Vector table, directed corner sequences and random refill traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache_refill_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         miss_req = 1'b0;
    logic [31:0]  miss_addr = '0;
    logic         kill = 1'b0;
    logic         mem_ack = 1'b0;
    logic [31:0]  mem_rdata = '0;
    logic         miss_ack, busy, mem_req, ram_req, ram_wr_en;
    logic [31:0]  mem_addr;
    logic [10:0]  ram_addr;
    logic [127:0] ram_wdata;

    icache_refill_ctrl #(
        .LINE_WIDTH(128),
        .BEAT_WIDTH(32),
        .ADDR_WIDTH(11)
    ) dut (
        .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
        .kill(kill), .miss_ack(miss_ack), .busy(busy), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ram_req(ram_req), .ram_wr_en(ram_wr_en), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_ramreq = 0;
    int n_missack = 0;

    // Reference model: a refill is "active" while collecting words, then one write cycle.
    bit          m_active, m_wr, m_killed;
    int          m_cnt;
    logic [31:0] m_base;
    logic [31:0] m_words [4];

    typedef struct {
        logic         rst, miss, kill, ack;
        logic [31:0]  addr, rdata;
        logic         busy, mreq, wr;
        logic [31:0]  maddr;
        logic [10:0]  raddr;
        logic [127:0] wdata;
    } vec_t;
    vec_t vt [8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic m, input logic [31:0] a,
                         input logic k, input logic ack, input logic [31:0] d);
        rst = r; miss_req = m; miss_addr = a; kill = k; mem_ack = ack; mem_rdata = d;
    endtask

    task automatic model_step();
        if (rst) begin
            m_active = 0; m_wr = 0; m_killed = 0; m_cnt = 0; m_base = '0;
            for (int i = 0; i < 4; i++) m_words[i] = '0;
        end else if (m_wr) begin
            m_wr = 0;
        end else if (m_active) begin
            if (mem_ack) begin
                m_words[m_cnt % 4] = mem_rdata;
                m_cnt++;
                if (m_killed || kill) m_active = 0;
                else if (m_cnt == 4) begin m_active = 0; m_wr = 1; end
            end else if (kill) begin
                m_killed = 1;
            end
        end else if (miss_req) begin
            m_base = {miss_addr[31:4], 4'h0};
            m_cnt = 0; m_killed = 0; m_active = 1;
        end
    endtask

    task automatic check_model();
        chk("busy", busy, m_active || m_wr);
        chk("mem_req", mem_req, m_active);
        chk("mem_addr", mem_addr, m_base + 32'((m_cnt % 4) * 4));
        chk("ram_req", ram_req, m_wr);
        chk("ram_wr_en", ram_wr_en, m_wr);
        chk("miss_ack", miss_ack, m_wr);
        chk("ram_addr", ram_addr, m_base[14:4]);
        chk("ram_wdata", ram_wdata, {m_words[3], m_words[2], m_words[1], m_words[0]});
    endtask

    task automatic step();
        check_model();
        if (ram_req) n_ramreq++;
        if (miss_ack) n_missack++;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_mem_req"}, mem_req, 1'b0);
        chk({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk({tag, "_ram_req"}, ram_req, 1'b0);
        chk({tag, "_miss_ack"}, miss_ack, 1'b0);
        chk({tag, "_ram_addr"}, ram_addr, 11'h0);
        chk({tag, "_ram_wdata"}, ram_wdata, 128'h0);
    endtask

    initial begin
        vt[0] = '{0,1,0,0, 32'h1230, 32'h0,        0,0,0, 32'h0,    11'h000, 128'h0};
        vt[1] = '{0,0,0,1, 32'h0, 32'h11111111,    1,1,0, 32'h1230, 11'h123, 128'h0};
        vt[2] = '{0,0,0,1, 32'h0, 32'h22222222,    1,1,0, 32'h1234, 11'h123, 128'h11111111};
        vt[3] = '{0,0,0,1, 32'h0, 32'h33333333,    1,1,0, 32'h1238, 11'h123, 128'h22222222_11111111};
        vt[4] = '{0,0,0,1, 32'h0, 32'h44444444,    1,1,0, 32'h123C, 11'h123, 128'h33333333_22222222_11111111};
        vt[5] = '{0,0,0,0, 32'h0, 32'h0,           1,0,1, 32'h1230, 11'h123, 128'h44444444_33333333_22222222_11111111};
        vt[6] = '{0,0,0,1, 32'h0, 32'hDEADBEEF,    0,0,0, 32'h1230, 11'h123, 128'h44444444_33333333_22222222_11111111};
        vt[7] = '{0,0,0,0, 32'h0, 32'h0,           0,0,0, 32'h1230, 11'h123, 128'h44444444_33333333_22222222_11111111};

        drive(1, 0, 0, 0, 0, 0);
        repeat (2) begin @(posedge clk); model_step(); #1; end
        drive(0, 0, 0, 0, 0, 0);

        // Best-case refill and idle mem_ack, cycle by cycle from the table.
        for (int i = 0; i < 8; i++) begin
            drive(vt[i].rst, vt[i].miss, vt[i].addr, vt[i].kill, vt[i].ack, vt[i].rdata);
            chk($sformatf("vec%0d_busy", i), busy, vt[i].busy);
            chk($sformatf("vec%0d_mem_req", i), mem_req, vt[i].mreq);
            chk($sformatf("vec%0d_mem_addr", i), mem_addr, vt[i].maddr);
            chk($sformatf("vec%0d_ram_req", i), ram_req, vt[i].wr);
            chk($sformatf("vec%0d_ram_wr_en", i), ram_wr_en, vt[i].wr);
            chk($sformatf("vec%0d_miss_ack", i), miss_ack, vt[i].wr);
            chk($sformatf("vec%0d_ram_addr", i), ram_addr, vt[i].raddr);
            chk($sformatf("vec%0d_ram_wdata", i), ram_wdata, vt[i].wdata);
            @(posedge clk); model_step(); #1;
        end

        // Slow memory: three idle cycles before each beat ack.
        n_missack = 0;
        drive(0, 1, 32'h0004_5670, 0, 0, 0); step();
        for (int b = 0; b < 4; b++) begin
            for (int w = 0; w < 3; w++) begin
                drive(0, 0, 0, 0, 0, 0);
                chk("slow_mem_addr_stable", mem_addr, 32'h0004_5670 + 32'(b * 4));
                step();
            end
            drive(0, 0, 0, 0, 1, $urandom); step();
        end
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) step();
        chk("slow_miss_ack_count", 128'(n_missack), 128'd1);

        // Kill while waiting for beat 1: that beat completes, nothing is written.
        n_ramreq = 0; n_missack = 0;
        drive(0, 1, 32'h0000_8A40, 0, 0, 0); step();
        drive(0, 0, 0, 0, 1, 32'hA0A0A0A0); step();
        drive(0, 0, 0, 1, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 1, 32'hB1B1B1B1); step();
        drive(0, 0, 0, 0, 0, 0);
        chk("kill_busy_dropped", busy, 1'b0);
        repeat (3) step();
        chk("kill_ram_req_count", 128'(n_ramreq), 128'd0);
        chk("kill_miss_ack_count", 128'(n_missack), 128'd0);

        // miss_req held through a refill: next refill starts only after the IDLE cycle.
        n_missack = 0;
        drive(0, 1, 32'h0000_0100, 0, 1, $urandom);
        for (int c = 0; c < 6; c++) step();
        chk("held_idle_gap", busy, 1'b0);
        for (int c = 0; c < 7; c++) begin mem_rdata = $urandom; step(); end
        chk("held_miss_ack_count", 128'(n_missack), 128'd2);

        // Reset in the cycle after beat 2 ack, then a clean refill.
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) step();
        drive(0, 1, 32'h0000_3FF0, 0, 0, 0); step();
        for (int b = 0; b < 3; b++) begin drive(0, 0, 0, 0, 1, $urandom); step(); end
        drive(1, 0, 0, 0, 1, 32'hFFFFFFFF); step();
        drive(0, 0, 0, 0, 0, 0);
        chk_all_zero("rst_mid");
        n_missack = 0;
        drive(0, 1, 32'h0000_7770, 0, 1, 32'h0BADF00D);
        step();
        chk("rst_restart_beat0_addr", mem_addr, 32'h0000_7770);
        for (int b = 0; b < 5; b++) begin drive(0, 0, 0, 0, 1, $urandom); step(); end
        chk("rst_restart_miss_ack_count", 128'(n_missack), 128'd1);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0, $urandom,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, $urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
